// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation-select width and mode encodings.
package shift_reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;
    localparam logic [MODE_W-1:0] MODE_INV  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

endpackage

// File: rtl/dff_en.sv
// One-bit storage cell with load enable, asynchronous active-low reset to a per-bit value,
// and a complement output derived from the stored bit.
module dff_en (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    input  logic rstval,
    output logic q,
    output logic qn
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = en ? d : q_q;
    end

    // rstval is tied to a constant by the parent, so this is a plain set/reset flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= rstval;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: rtl/shift_reg_univ.sv
// WIDTH-bit universal register: hold, load, shift, rotate, invert and synchronous clear,
// built from one dff_en cell per bit with the next-state mux kept here.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic              sout_msb,
    output logic              sout_lsb
);

    logic [WIDTH-1:0] q_int;
    logic [WIDTH-1:0] qn_int;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] rotl_val;
    logic [WIDTH-1:0] rotr_val;
    logic [WIDTH-1:0] op_val;
    logic [WIDTH-1:0] next_val;
    logic             cell_en;

    // A one-bit register has no neighbours: shifts take the serial input and rotates hold.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign shl_val  = sin_r;
            assign shr_val  = sin_l;
            assign rotl_val = q_int;
            assign rotr_val = q_int;
        end else begin : g_wide
            assign shl_val  = {q_int[WIDTH-2:0], sin_r};
            assign shr_val  = {sin_l, q_int[WIDTH-1:1]};
            assign rotl_val = {q_int[WIDTH-2:0], q_int[WIDTH-1]};
            assign rotr_val = {q_int[0], q_int[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        op_val = q_int;
        case (mode)
            MODE_HOLD: op_val = q_int;
            MODE_LOAD: op_val = d;
            MODE_SHL:  op_val = shl_val;
            MODE_SHR:  op_val = shr_val;
            MODE_ROTL: op_val = rotl_val;
            MODE_ROTR: op_val = rotr_val;
            MODE_INV:  op_val = ~q_int;
            MODE_RSVD: op_val = q_int;
            default:   op_val = q_int;
        endcase
    end

    // Clear overrides the enable, so the cells are enabled whenever either is asserted.
    always_comb begin
        next_val = clr ? RESET_VAL : op_val;
        cell_en  = clr | en;
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            dff_en u_cell (
                .clk    (clk),
                .rst    (rst),
                .en     (cell_en),
                .d      (next_val[i]),
                .rstval (RESET_VAL[i]),
                .q      (q_int[i]),
                .qn     (qn_int[i])
            );
        end
    endgenerate

    assign q        = q_int;
    assign qn       = qn_int;
    assign sout_msb = q_int[WIDTH-1];
    assign sout_lsb = q_int[0];

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit universal register with true and complement outputs.
- Supports hold, parallel load, logical shift left/right with serial inputs, rotate left/right, bitwise invert and synchronous clear.
- Used as the general storage/shift element in datapaths: serial links, LFSR front-ends and staging registers.
- Single clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 8, register width in bits; legal range 1..64.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset and on sync clear.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low; rst=0 forces q=RESET_VAL immediately.
- en  input  1  operation enable; en=0 holds q, except for clr.
- clr  input  1  synchronous clear to RESET_VAL; ignores en.
- mode  input  3  operation select; encodings under Behaviour.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at the MSB on shift right.
- sin_r  input  1  serial input entering at the LSB on shift left.
- q  output  WIDTH  registered state.
- qn  output  WIDTH  ~q, combinational from q (no extra register).
- sout_msb  output  1  q[WIDTH-1].
- sout_lsb  output  1  q[0].

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-low.
- Reset: rst falling sets q=RESET_VAL without waiting for clk. While rst=0:
  - q stays RESET_VAL;
  - qn=~RESET_VAL;
  - sout_msb/sout_lsb reflect RESET_VAL.
- Reset release: the first active edge is the first rising clk edge with rst=1. Releasing reset mid-cycle must not glitch q.
- Priority at each rising edge: rst=0 > clr=1 > en=0 (hold) > mode.
- Latency: every operation is visible on q one edge after sampling. qn, sout_msb and sout_lsb follow q in the same cycle.
- Mode encodings (applied when en=1, clr=0):
  - 000 HOLD: q unchanged.
  - 001 LOAD: q <= d.
  - 010 SHL: q <= {q[WIDTH-2:0], sin_r}.
  - 011 SHR: q <= {sin_l, q[WIDTH-1:1]}.
  - 100 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROTR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 INV: q <= ~q.
  - 111 reserved: behaves as HOLD. It must never produce X.
- WIDTH=1 boundary:
  - SHL gives q <= sin_r; SHR gives q <= sin_l.
  - ROTL/ROTR act as HOLD.
  - sout_msb = sout_lsb = q[0].
  - No out-of-range slice may be elaborated; guard with generate.
- Simultaneous events:
  - clr=1 with any mode or en: clear wins.
  - rst asserted on the same edge as any operation: reset wins.
- Serial inputs are sampled only in SHL/SHR. They are don't-care otherwise.
- d is sampled only in LOAD.
- No internal state other than q. The block has no FSM beyond the mode mux; the next-state function is purely combinational from (q, mode, d, sin_l, sin_r).

Decomposition:
- Shared package shift_reg_pkg:
  - localparams MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_INV, MODE_RSVD;
  - MODE_W=3.
- Sub-module dff_en: one-bit cell with ports clk, rst (async active-low), en, d, rstval, q, qn.
  - shift_reg_univ instantiates WIDTH cells via generate.
  - The next-state mux (including clr) stays in the parent.

Test Plan (WIDTH=8, RESET_VAL=8'h00 unless stated):
- Async reset: drive rst=0 mid-cycle with q=8'hA5 -> q=8'h00 and qn=8'hFF before the next clk edge; release, then LOAD d=8'h3C -> q=8'h3C after one edge.
- Shift chain: LOAD 8'h81, then SHL with sin_r=0 for 3 edges -> q=8'h08, sout_msb=0; then SHR with sin_l=1 for 2 edges -> q=8'hC2.
- Rotate wrap: LOAD 8'h80, ROTL 1 edge -> q=8'h01; ROTR 2 edges -> q=8'h40; ROTR×8 from 8'h40 -> q=8'h40.
- Priority: en=0 with mode=LOAD, d=8'hFF -> q unchanged; clr=1 with en=0 and mode=INV -> q=RESET_VAL; mode=111 -> q unchanged, no X.
- INV: LOAD 8'h5A, INV -> q=8'hA5, qn=8'h5A; INV again -> q=8'h5A.
- WIDTH=1, RESET_VAL=1'b1: after reset q=1; SHL sin_r=0 -> q=0; ROTL -> q=0; SHR sin_l=1 -> q=1; sout_msb==sout_lsb throughout.
